fp_div_seq: RTL and testbench
=============================

// Module: fp_div_seq
// PURPOSE
//  Iterative single-precision (IEEE-754 binary32) divider: the inverse operator to
//  the fpMul multiplier, used by the CNN datapath for normalisation and averaging
//  (divide-by-count). Produces one restoring-division quotient bit per clock.
//  Exposes the unpacked fields (sign, exponent, fraction), as fpMul does, plus the
//  packed word. Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MANT_W  23   stored fraction width
//  BIAS    127  exponent bias
// PORTS
//  clk        in   1   single clock; all state changes on posedge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   block idle, can accept (state==IDLE && !rst)
//  flp_a      in   32  dividend (binary32)
//  flp_b      in   32  divisor  (binary32)
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  32  packed quotient {sign, exponent, quot}
//  sign       out  1   quotient sign
//  exponent   out  8   biased quotient exponent
//  quot       out  23  quotient fraction (truncated)
//  div_by_zero out 1   flp_b was +/-0 and flp_a finite non-zero
//  invalid    out  1   NaN operand, 0/0 or inf/inf
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, result, sign, exponent, quot, flags = 0; in_ready=0
//   while rst is high, 1 from the first cycle after it drops. A reset mid-division
//   aborts the operation; no result is produced for it.
//  FSM: IDLE -> (in_valid) -> ITER (25 cycles) -> NORM (1) -> DONE -> (out_ready) -> IDLE.
//   Special cases: IDLE -> DONE directly (result valid on cycle 1 after accept).
//  Accept: captured on a clk edge where in_valid && in_ready. Latency is 27 cycles
//   for normal operands: out_valid rises on the 27th edge after accept.
//  Denormal inputs are treated as zero (flush-to-zero). Hidden 1 is prepended to
//   normal fractions: ma,mb are 24 bits wide.
//  sign = a[31]^b[31] always, including the special cases below.
//  ITER: restoring division of {ma,24'b0} by mb gives a 25-bit quotient q.
//   One bit per cycle, MSB first; a 5-bit counter counts 24 down to 0.
//  Exponent: signed 10-bit e = ea - eb + BIAS.
//  NORM: if q[24]: quot=q[23:1], exp=e; else quot=q[22:0], exp=e-1.
//   Rounding is truncation, matching fpMul. No remainder or sticky bit is used.
//  Range checks on the final exp: exp>=255 -> +/-inf (exponent=8'hFF, quot=0);
//   exp<=0 -> +/-0 (underflow flushes; no flag is raised).
//  Specials, with precedence top-down:
//   - a or b NaN, 0/0 or inf/inf -> result 32'h7FC00000, invalid=1.
//   - a inf                      -> +/-inf.
//   - b zero                     -> +/-inf, div_by_zero=1.
//   - a zero or b inf            -> +/-0.
//  DONE: outputs stable while out_valid && !out_ready. On the handshake edge the
//   FSM returns to IDLE and out_valid clears; the output fields hold their last
//   values. A new accept is possible on the edge after that (no bypass).
//  Flags are cleared at every accept.
// STRUCTURE
//  Shared package fp_pkg: FP32_EXP_W, FP32_MANT_W, FP32_BIAS, FP32_QNAN (7FC00000),
//   FP32_INF_EXP, and a state enum type fp_div_state_t {IDLE,ITER,NORM,DONE}.
//  One sub-module, fp_classify: combinational per-operand decode to
//   {is_zero, is_inf, is_nan, mant24}. It is instantiated twice and reused by fpMul later.
//  Datapath: 25-bit partial remainder, 25-bit quotient shift register, and counter.
// TESTING
//  15/3: a=41700000 b=40400000 -> result=40A00000, out_valid at accept+27, no flags.
//  -25/5: a=C1C80000 b=40A00000 -> result=C0A00000, sign=1.
//  1/3: a=3F800000 b=40400000 -> result=3EAAAAAA (truncated; no NORM exp adjust
//   error). Exercises the q[24]=0 path.
//  Specials: 1/0 -> 7F800000 with div_by_zero=1 at accept+1; 0/0 -> 7FC00000 with
//   invalid=1; 0/7 (0/40E00000) -> 00000000; 7F7FFFFF/00800000 -> 7F800000.
//  Backpressure: hold out_ready=0 for 10 cycles after out_valid. result is stable
//   and in_ready=0 throughout; in_valid is ignored. Then pulse out_ready: IDLE,
//   and the next op is accepted the following cycle.
//  Reset mid-op: assert rst at accept+10 for 1 cycle. Then out_valid=0 and all
//   outputs are 0; no result for the aborted op; the next op (6/4 -> 3FC00000)
//   completes in 27 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 constants and divider state type.
// Imported by the divider and the operand classifier.
package fp_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_BIAS = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [7:0] FP32_INF_EXP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    NORM,
    DONE
  } fp_div_state_t;

endpackage

// File: rtl/fp_div_seq_classify.sv
// Per-operand decode: zero (denormals flushed), inf, NaN and the
// significand with its hidden bit restored.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = FP32_EXP_W,
  parameter int MANT_W = FP32_MANT_W
) (
  input  logic [EXP_W+MANT_W-1:0] x,
  output logic                    is_zero,
  output logic                    is_inf,
  output logic                    is_nan,
  output logic [MANT_W:0]         mant
);

  logic [EXP_W-1:0] e;
  logic [MANT_W-1:0] f;

  assign e = x[EXP_W+MANT_W-1 -: EXP_W];
  assign f = x[MANT_W-1:0];

  assign is_zero = (e == '0);
  assign is_inf = (&e) && (f == '0);
  assign is_nan = (&e) && (f != '0);
  assign mant = is_zero ? '0 : {1'b1, f};

endmodule

// File: rtl/fp_div_seq.sv
// Iterative binary32 divider, one restoring quotient bit per clock.
// Truncating, flush-to-zero, valid/ready on both sides.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = FP32_EXP_W,
  parameter int MANT_W = FP32_MANT_W,
  parameter int BIAS = FP32_BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   flp_a,
  input  logic [EXP_W+MANT_W:0]   flp_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    sign,
  output logic [EXP_W-1:0]        exponent,
  output logic [MANT_W-1:0]       quot,
  output logic                    div_by_zero,
  output logic                    invalid
);

  localparam int W = EXP_W + MANT_W + 1;
  localparam int QW = MANT_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [4:0] CNT_INIT = 5'(MANT_W + 1);
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] ONE_S = EW'(1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MANT_W-1:0] QNAN_Q = {1'b1, {(MANT_W-1){1'b0}}};

  fp_div_state_t state, next;

  logic za, ia, na, zb, ib, nb;
  logic [MANT_W:0] ma, mb;
  logic accept, special;

  logic [QW-1:0] rem, qsr;
  logic [MANT_W:0] mb_r;
  logic [4:0] cnt;
  logic signed [EW-1:0] e_r;
  logic s_r;

  logic [EXP_W-1:0] st_exp;
  logic [MANT_W-1:0] st_quot;
  logic st_dbz, st_inv;

  logic [EXP_W-1:0] sp_exp;
  logic [MANT_W-1:0] sp_quot;
  logic sp_dbz, sp_inv;

  logic qb;
  logic [MANT_W:0] diff;
  logic [QW-1:0] rem_nx;

  logic signed [EW-1:0] e_adj;
  logic [MANT_W-1:0] n_quot;
  logic [EXP_W-1:0] n_exp;
  logic [MANT_W-1:0] n_frac;

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
    .x(flp_a[W-2:0]),
    .is_zero(za),
    .is_inf(ia),
    .is_nan(na),
    .mant(ma)
  );

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
    .x(flp_b[W-2:0]),
    .is_zero(zb),
    .is_inf(ib),
    .is_nan(nb),
    .mant(mb)
  );

  assign accept = in_valid && in_ready;
  assign special = na | nb | ia | ib | za | zb;

  // Priority matters: NaN/indeterminate beats inf dividend beats x/0.
  always_comb begin
    sp_exp = '0;
    sp_quot = '0;
    sp_dbz = 1'b0;
    sp_inv = 1'b0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      sp_exp = EXP_ONES;
      sp_quot = QNAN_Q;
      sp_inv = 1'b1;
    end else if (ia) begin
      sp_exp = EXP_ONES;
    end else if (zb) begin
      sp_exp = EXP_ONES;
      sp_dbz = 1'b1;
    end
  end

  // rem < 2*mb, so a successful subtract always fits back in MANT_W+1 bits.
  assign qb = (rem >= {1'b0, mb_r});
  assign diff = rem[QW-2:0] - mb_r;
  assign rem_nx = qb ? {diff, 1'b0} : {rem[QW-2:0], 1'b0};

  assign e_adj = qsr[QW-1] ? e_r : e_r - ONE_S;
  assign n_quot = qsr[QW-1] ? qsr[QW-2:1] : qsr[QW-3:0];

  always_comb begin
    n_exp = e_adj[EXP_W-1:0];
    n_frac = n_quot;
    if (e_adj >= EMAX) begin
      n_exp = EXP_ONES;
      n_frac = '0;
    end else if (e_adj[EW-1] || e_adj == ONE_S - ONE_S) begin
      n_exp = '0;
      n_frac = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (accept) next = special ? DONE : ITER;
      ITER: if (cnt == '0) next = NORM;
      NORM: next = DONE;
      DONE: if (out_valid && out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  assign result = invalid ? {1'b0, EXP_ONES, QNAN_Q}
                          : {sign, exponent, quot};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      qsr <= '0;
      mb_r <= '0;
      cnt <= '0;
      e_r <= '0;
      s_r <= 1'b0;
      st_exp <= '0;
      st_quot <= '0;
      st_dbz <= 1'b0;
      st_inv <= 1'b0;
      out_valid <= 1'b0;
      sign <= 1'b0;
      exponent <= '0;
      quot <= '0;
      div_by_zero <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            invalid <= 1'b0;
            s_r <= flp_a[W-1] ^ flp_b[W-1];
            rem <= {1'b0, ma};
            mb_r <= mb;
            qsr <= '0;
            cnt <= CNT_INIT;
            e_r <= {2'b00, flp_a[W-2 -: EXP_W]}
                 - {2'b00, flp_b[W-2 -: EXP_W]} + BIAS_S;
            st_exp <= sp_exp;
            st_quot <= sp_quot;
            st_dbz <= sp_dbz;
            st_inv <= sp_inv;
          end
        end
        ITER: begin
          rem <= rem_nx;
          qsr <= {qsr[QW-2:0], qb};
          cnt <= cnt - 5'd1;
        end
        NORM: begin
          st_exp <= n_exp;
          st_quot <= n_frac;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            sign <= s_r;
            exponent <= st_exp;
            quot <= st_quot;
            div_by_zero <= st_dbz;
            invalid <= st_inv;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq against an
// arithmetic reference model of binary32 truncating division.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [31:0] flp_a;
  logic [31:0] flp_b;
  logic out_valid;
  logic out_ready;
  logic [31:0] result;
  logic sign;
  logic [7:0] exponent;
  logic [22:0] quot;
  logic div_by_zero;
  logic invalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flp_a(flp_a),
    .flp_b(flp_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .sign(sign),
    .exponent(exponent),
    .quot(quot),
    .div_by_zero(div_by_zero),
    .invalid(invalid)
  );

  function automatic logic [31:0] ref_div(
    input logic [31:0] a, input logic [31:0] b,
    output bit dbz, output bit inv, output bit spec);
    int ea, eb, e;
    longint fa, fb, ma, mb, q, fr;
    bit za, zb, ia, ib, na, nb, s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    s = a[31] ^ b[31];
    dbz = 0;
    inv = 0;
    spec = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      inv = 1;
      return 32'h7FC00000;
    end
    if (ia) return {s, 8'hFF, 23'h0};
    if (zb) begin
      dbz = 1;
      return {s, 8'hFF, 23'h0};
    end
    if (za || ib) return {s, 31'h0};
    spec = 0;
    ma = fa + 64'd8388608;
    mb = fb + 64'd8388608;
    q = (ma * 64'd16777216) / mb;
    e = ea - eb + 127;
    if (q >= 64'd16777216) fr = (q / 2) % 64'd8388608;
    else begin
      fr = q % 64'd8388608;
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], fr[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int r;
    r = int'($urandom_range(0, 15));
    v = $urandom;
    if (r == 0) v[30:0] = '0;
    else if (r == 1) v[30:0] = {8'hFF, 23'h0};
    else if (r == 2) v[30:23] = 8'hFF;
    else if (r == 3) v[30:23] = 8'h00;
    else if (r == 4) v[30:23] = 8'($urandom_range(1, 254));
    else v[30:23] = 8'($urandom_range(110, 144));
    if (r == 2 && v[22:0] == '0) v[22] = 1'b1;
    return v;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int n;
    lat = -1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) return;
    flp_a = a;
    flp_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flp_a = '0;
    flp_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b result=%h want 0/0",
               out_valid, result);
    end
    checks++;
    if ({sign, exponent, quot, div_by_zero, invalid} !== '0) begin
      errors++;
      $display("FAIL reset_fields: %b %h %h %b %b want all 0",
               sign, exponent, quot, div_by_zero, invalid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8];
    logic [31:0] tb_ [8];
    logic [31:0] tr [8];
    bit tz [8];
    bit ti [8];
    int tl [8];
    int lat;
    ta = '{32'h41700000, 32'hC1C80000, 32'h3F800000, 32'h3F800000,
           32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'h00800000};
    tb_ = '{32'h40400000, 32'h40A00000, 32'h40400000, 32'h00000000,
            32'h00000000, 32'h40E00000, 32'h00800000, 32'h7F7FFFFF};
    tr = '{32'h40A00000, 32'hC0A00000, 32'h3EAAAAAA, 32'h7F800000,
           32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
    tz = '{0, 0, 0, 1, 0, 0, 0, 0};
    ti = '{0, 0, 0, 0, 1, 0, 0, 0};
    tl = '{27, 27, 27, 1, 1, 1, 27, 27};
    for (int k = 0; k < 8; k++) begin
      do_op(ta[k], tb_[k], lat);
      checks++;
      if (lat !== tl[k]) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, tl[k]);
      end
      checks++;
      if (result !== tr[k]) begin
        errors++;
        $display("FAIL dir_result[%0d]: got %h want %h", k, result, tr[k]);
      end
      checks++;
      if (div_by_zero !== tz[k] || invalid !== ti[k]) begin
        errors++;
        $display("FAIL dir_flags[%0d]: dbz=%b inv=%b want %b %b",
                 k, div_by_zero, invalid, tz[k], ti[k]);
      end
      checks++;
      if (sign !== (ta[k][31] ^ tb_[k][31])) begin
        errors++;
        $display("FAIL dir_sign[%0d]: got %b", k, sign);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, er;
    bit dbz, inv, spec;
    int lat;
    for (int k = 0; k < 40; k++) begin
      a = rand_fp();
      b = rand_fp();
      er = ref_div(a, b, dbz, inv, spec);
      do_op(a, b, lat);
      checks++;
      if (lat !== (spec ? 1 : 27)) begin
        errors++;
        $display("FAIL rnd_latency: a=%h b=%h got %0d", a, b, lat);
      end
      checks++;
      if (result !== er) begin
        errors++;
        $display("FAIL rnd_result: a=%h b=%h got %h want %h",
                 a, b, result, er);
      end
      checks++;
      if (div_by_zero !== dbz || invalid !== inv ||
          sign !== (a[31] ^ b[31])) begin
        errors++;
        $display("FAIL rnd_flags: a=%h b=%h dbz=%b inv=%b s=%b want %b %b",
                 a, b, div_by_zero, invalid, sign, dbz, inv);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    do_op(32'h41700000, 32'h40400000, lat);
    checks++;
    if (lat !== 27 || result !== 32'h40A00000) begin
      errors++;
      $display("FAIL bp_first: lat=%0d result=%h want 27 40A00000",
               lat, result);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      flp_a = 32'h3F800000;
      flp_b = 32'h40400000;
      @(posedge clk);
      #1;
      if (result !== 32'h40A00000 || in_ready !== 1'b0 ||
          out_valid !== 1'b1) bad = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: result=%h in_ready=%b out_valid=%b",
               result, in_ready, out_valid);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (result !== 32'h40A00000) begin
      errors++;
      $display("FAIL bp_fields_hold: got %h want 40A00000", result);
    end
    do_op(32'h3F800000, 32'h40400000, lat);
    checks++;
    if (lat !== 27 || result !== 32'h3EAAAAAA) begin
      errors++;
      $display("FAIL bp_next: lat=%0d result=%h want 27 3EAAAAAA",
               lat, result);
    end
    release_out();
  endtask

  task automatic test_reset_mid_op();
    int lat, n;
    bit seen;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    flp_a = 32'h41700000;
    flp_b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 ||
        {sign, exponent, quot, div_by_zero, invalid} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: out_valid=%b result=%h", out_valid, result);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_no_result: got out_valid=1 want 0");
    end
    do_op(32'h40C00000, 32'h40800000, lat);
    checks++;
    if (lat !== 27 || result !== 32'h3FC00000) begin
      errors++;
      $display("FAIL midrst_next: lat=%0d result=%h want 27 3FC00000",
               lat, result);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, er;
    bit dbz, inv, spec;
    int lat;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      er = ref_div(a, b, dbz, inv, spec);
      do_op(a, b, lat);
      checks++;
      if (lat !== 27 || result !== er) begin
        errors++;
        $display("FAIL b2b[%0d]: a=%h b=%h lat=%0d got %h want %h",
                 k, a, b, lat, result, er);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
